// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline stream, long-latency result handshake,
// issue/scoreboard query and the register-file write port.
interface wb_arbiter_if #(
  parameter int CW = 2
);
  logic               pipe_we;
  logic [4:0]         pipe_wr;
  logic signed [31:0] pipe_wd;
  logic               lu_valid;
  logic [4:0]         lu_wr;
  logic signed [31:0] lu_wd;
  logic               lu_ready;
  logic               issue_en;
  logic [4:0]         issue_wr;
  logic [4:0]         chk_r1;
  logic [4:0]         chk_r2;
  logic               chk_busy;
  logic               regWrite;
  logic [4:0]         writeR;
  logic signed [31:0] writeD;
  logic [CW-1:0]      fifo_count;

  modport master (
    output pipe_we, pipe_wr, pipe_wd, lu_valid, lu_wr, lu_wd,
           issue_en, issue_wr, chk_r1, chk_r2,
    input  lu_ready, chk_busy, regWrite, writeR, writeD, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_wr, pipe_wd, lu_valid, lu_wr, lu_wd,
           issue_en, issue_wr, chk_r1, chk_r2,
    output lu_ready, chk_busy, regWrite, writeR, writeD, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Owns the register-file write port: pipeline writes take priority, long-latency
// results drain in order from a small FIFO, and a busy scoreboard tracks them.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [4:0]         fifo_wr_q [DEPTH];
  logic signed [31:0] fifo_wd_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic [31:0]        busy_q;
  logic [31:0]        busy_d;
  logic               regwrite_q;
  logic [4:0]         write_r_q;
  logic signed [31:0] write_d_q;

  logic               lu_ready;
  logic               pipe_eff;
  logic               enq;
  logic               deq;
  logic [4:0]         head_wr;
  logic signed [31:0] head_wd;

  // Ready depends only on current occupancy; a same-cycle dequeue gives no credit.
  assign lu_ready = !rst && (count_q < DEPTH_C);
  assign pipe_eff = bus.pipe_we && (bus.pipe_wr != 5'd0);
  assign enq      = bus.lu_valid && lu_ready && (bus.lu_wr != 5'd0);
  assign deq      = !pipe_eff && (count_q != '0);
  assign head_wr  = fifo_wr_q[rd_ptr_q];
  assign head_wd  = fifo_wd_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A new issue to a register outranks a same-edge completion of that register.
  assign busy_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_d[gi] = (bus.issue_en && (bus.issue_wr == 5'(gi)))
                        | (busy_q[gi] && !(deq && (head_wr == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_wr_q[wr_ptr_q] <= bus.lu_wr;
      fifo_wd_q[wr_ptr_q] <= bus.lu_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      write_r_q  <= 5'd0;
      write_d_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= '0;
    end else begin
      regwrite_q <= pipe_eff || deq;
      if (pipe_eff) begin
        write_r_q <= bus.pipe_wr;
        write_d_q <= bus.pipe_wd;
      end else if (deq) begin
        write_r_q <= head_wr;
        write_d_q <= head_wd;
      end
      if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.lu_ready   = lu_ready;
  assign bus.chk_busy   = busy_q[bus.chk_r1] | busy_q[bus.chk_r2];
  assign bus.regWrite   = regwrite_q;
  assign bus.writeR     = write_r_q;
  assign bus.writeD     = write_d_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the writeback port.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.CW(CW)) bus ();
  wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  wr;
    logic [31:0] wd;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_busy = '0;
  logic        m_regw = 1'b0;
  logic [4:0]  m_wr   = '0;
  logic [31:0] m_wd   = '0;

  function automatic logic m_ready();
    return !rst && (mq.size() < DEPTH);
  endfunction

  function automatic logic m_chk(input logic [4:0] a, input logic [4:0] b);
    return m_busy[a] | m_busy[b];
  endfunction

  task automatic set_idle();
    bus.pipe_we  = 1'b0; bus.pipe_wr = '0; bus.pipe_wd = '0;
    bus.lu_valid = 1'b0; bus.lu_wr   = '0; bus.lu_wd   = '0;
    bus.issue_en = 1'b0; bus.issue_wr = '0;
  endtask

  // Advance the model by one edge using the current inputs, then step the DUT.
  task automatic step();
    ent_t e;
    logic rdy;
    rdy = m_ready();
    if (rst) begin
      mq.delete();
      m_busy = '0; m_regw = 1'b0; m_wr = '0; m_wd = '0;
    end else begin
      if (bus.pipe_we && bus.pipe_wr != 0) begin
        m_regw = 1'b1; m_wr = bus.pipe_wr; m_wd = bus.pipe_wd;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_regw = 1'b1; m_wr = e.wr; m_wd = e.wd;
        m_busy[e.wr] = 1'b0;
      end else begin
        m_regw = 1'b0;
      end
      if (bus.lu_valid && rdy && bus.lu_wr != 0) begin
        e.wr = bus.lu_wr; e.wd = bus.lu_wd;
        mq.push_back(e);
      end
      if (bus.issue_en && bus.issue_wr != 0) m_busy[bus.issue_wr] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (m_regw) $display("wb r%0d <= %0d", m_wr, $signed(m_wd));
  endtask

  task automatic test_reset();
    set_idle();
    bus.chk_r1 = '0; bus.chk_r2 = '0;
    rst = 1'b1;
    #1;
    checks++; if (bus.lu_ready !== 1'b0) begin failures++; $display("FAIL rst_lu_ready_in_reset got=%0b exp=0", bus.lu_ready); end
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (bus.regWrite !== 1'b0) begin failures++; $display("FAIL rst_regWrite got=%0b exp=0", bus.regWrite); end
    checks++; if (bus.writeR !== 5'd0) begin failures++; $display("FAIL rst_writeR got=%0d exp=0", bus.writeR); end
    checks++; if (bus.fifo_count !== 2'd0) begin failures++; $display("FAIL rst_fifo_count got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL rst_lu_ready got=%0b exp=1", bus.lu_ready); end
    for (int i = 0; i < 4; i++) begin
      bus.chk_r1 = 5'($urandom_range(0, 31));
      bus.chk_r2 = 5'($urandom_range(0, 31));
      #1;
      checks++; if (bus.chk_busy !== 1'b0) begin failures++; $display("FAIL rst_chk_busy r1=%0d r2=%0d got=%0b exp=0", bus.chk_r1, bus.chk_r2, bus.chk_busy); end
    end
    step();
  endtask

  task automatic test_pipe_write();
    set_idle();
    bus.pipe_we = 1'b1; bus.pipe_wr = 5'd5; bus.pipe_wd = -32'sd7;
    step();
    checks++; if (bus.regWrite !== 1'b1) begin failures++; $display("FAIL pipe_regWrite got=%0b exp=1", bus.regWrite); end
    checks++; if (bus.writeR !== 5'd5) begin failures++; $display("FAIL pipe_writeR got=%0d exp=5", bus.writeR); end
    checks++; if (bus.writeD !== 32'hFFFF_FFF9) begin failures++; $display("FAIL pipe_writeD got=%0d exp=-7", bus.writeD); end
    set_idle();
    step();
    checks++; if (bus.regWrite !== 1'b0) begin failures++; $display("FAIL pipe_idle_regWrite got=%0b exp=0", bus.regWrite); end
    bus.pipe_we = 1'b1; bus.pipe_wr = 5'd0; bus.pipe_wd = -32'sd7;
    step();
    checks++; if (bus.regWrite !== 1'b0) begin failures++; $display("FAIL pipe_r0_regWrite got=%0b exp=0", bus.regWrite); end
    checks++; if (bus.writeR !== 5'd5) begin failures++; $display("FAIL pipe_r0_writeR_hold got=%0d exp=5", bus.writeR); end
    set_idle();
    step();
  endtask

  task automatic test_issue_complete();
    set_idle();
    bus.issue_en = 1'b1; bus.issue_wr = 5'd9;
    step();
    set_idle();
    bus.chk_r1 = 5'd9; bus.chk_r2 = 5'd0;
    #1;
    checks++; if (bus.chk_busy !== 1'b1) begin failures++; $display("FAIL issue_chk_busy got=%0b exp=1", bus.chk_busy); end
    bus.lu_valid = 1'b1; bus.lu_wr = 5'd9; bus.lu_wd = 32'sd100;
    step();
    set_idle();
    checks++; if (bus.fifo_count !== 2'd1) begin failures++; $display("FAIL lu_enq_count got=%0d exp=1", bus.fifo_count); end
    checks++; if (bus.regWrite !== 1'b0) begin failures++; $display("FAIL lu_no_bypass got=%0b exp=0", bus.regWrite); end
    step();
    checks++; if (bus.regWrite !== 1'b1) begin failures++; $display("FAIL lu_regWrite got=%0b exp=1", bus.regWrite); end
    checks++; if (bus.writeR !== 5'd9) begin failures++; $display("FAIL lu_writeR got=%0d exp=9", bus.writeR); end
    checks++; if (bus.writeD !== 32'd100) begin failures++; $display("FAIL lu_writeD got=%0d exp=100", bus.writeD); end
    checks++; if (bus.chk_busy !== 1'b0) begin failures++; $display("FAIL lu_busy_clear got=%0b exp=0", bus.chk_busy); end
    checks++; if (bus.fifo_count !== 2'd0) begin failures++; $display("FAIL lu_deq_count got=%0d exp=0", bus.fifo_count); end
    step();
  endtask

  task automatic test_priority_backpressure();
    set_idle();
    bus.pipe_we = 1'b1; bus.pipe_wr = 5'd7; bus.pipe_wd = 32'sd1;
    bus.lu_valid = 1'b1; bus.lu_wr = 5'd3; bus.lu_wd = 32'sd30;
    step();
    bus.pipe_wd = 32'sd2;
    bus.lu_wr = 5'd4; bus.lu_wd = 32'sd40;
    step();
    checks++; if (bus.fifo_count !== 2'd2) begin failures++; $display("FAIL bp_full_count got=%0d exp=2", bus.fifo_count); end
    checks++; if (bus.writeD !== 32'd2) begin failures++; $display("FAIL bp_pipe2_writeD got=%0d exp=2", bus.writeD); end
    bus.pipe_wd = 32'sd3;
    bus.lu_wr = 5'd5; bus.lu_wd = 32'sd50;
    #1;
    checks++; if (bus.lu_ready !== 1'b0) begin failures++; $display("FAIL bp_lu_ready_full got=%0b exp=0", bus.lu_ready); end
    step();
    checks++; if (bus.writeR !== 5'd7 || bus.writeD !== 32'd3) begin failures++; $display("FAIL bp_pipe3 got=r%0d/%0d exp=r7/3", bus.writeR, bus.writeD); end
    checks++; if (bus.fifo_count !== 2'd2) begin failures++; $display("FAIL bp_held_count got=%0d exp=2", bus.fifo_count); end
    set_idle();
    step();
    checks++; if (bus.regWrite !== 1'b1 || bus.writeR !== 5'd3 || bus.writeD !== 32'd30) begin failures++; $display("FAIL bp_first got=%0b r%0d/%0d exp=1 r3/30", bus.regWrite, bus.writeR, bus.writeD); end
    checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL bp_lu_ready_back got=%0b exp=1", bus.lu_ready); end
    step();
    checks++; if (bus.regWrite !== 1'b1 || bus.writeR !== 5'd4 || bus.writeD !== 32'd40) begin failures++; $display("FAIL bp_second got=%0b r%0d/%0d exp=1 r4/40", bus.regWrite, bus.writeR, bus.writeD); end
    step();
    checks++; if (bus.regWrite !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0b exp=0", bus.regWrite); end
  endtask

  task automatic test_mid_reset();
    set_idle();
    bus.issue_en = 1'b1; bus.issue_wr = 5'd3;
    bus.pipe_we = 1'b1; bus.pipe_wr = 5'd7; bus.pipe_wd = 32'sd8;
    bus.lu_valid = 1'b1; bus.lu_wr = 5'd3; bus.lu_wd = 32'sd5;
    step();
    bus.issue_en = 1'b0;
    bus.lu_wr = 5'd4; bus.lu_wd = 32'sd6;
    step();
    set_idle();
    bus.chk_r1 = 5'd0; bus.chk_r2 = 5'd3;
    #1;
    checks++; if (bus.fifo_count !== 2'd2 || bus.chk_busy !== 1'b1) begin failures++; $display("FAIL mr_pre count=%0d busy=%0b exp=2/1", bus.fifo_count, bus.chk_busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.regWrite !== 1'b0) begin failures++; $display("FAIL mr_regWrite got=%0b exp=0", bus.regWrite); end
    checks++; if (bus.fifo_count !== 2'd0) begin failures++; $display("FAIL mr_count got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.chk_busy !== 1'b0) begin failures++; $display("FAIL mr_busy got=%0b exp=0", bus.chk_busy); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.regWrite !== 1'b0) begin failures++; $display("FAIL mr_after%0d got=%0b exp=0", i, bus.regWrite); end
    end
  endtask

  task automatic test_same_edge();
    set_idle();
    bus.issue_en = 1'b1; bus.issue_wr = 5'd3;
    bus.lu_valid = 1'b1; bus.lu_wr = 5'd3; bus.lu_wd = 32'sd11;
    step();
    bus.lu_valid = 1'b0;
    step();
    set_idle();
    bus.chk_r1 = 5'd0; bus.chk_r2 = 5'd3;
    #1;
    checks++; if (bus.regWrite !== 1'b1 || bus.writeR !== 5'd3) begin failures++; $display("FAIL se_emit got=%0b r%0d exp=1 r3", bus.regWrite, bus.writeR); end
    checks++; if (bus.chk_busy !== 1'b1) begin failures++; $display("FAIL se_busy got=%0b exp=1", bus.chk_busy); end
    step();
    checks++; if (bus.chk_busy !== 1'b1) begin failures++; $display("FAIL se_busy_hold got=%0b exp=1", bus.chk_busy); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 99) < 2);
      bus.pipe_we  = ($urandom_range(0, 99) < 35);
      bus.pipe_wr  = 5'($urandom_range(0, 7));
      bus.pipe_wd  = $urandom;
      bus.lu_valid = ($urandom_range(0, 99) < 50);
      bus.lu_wr    = 5'($urandom_range(0, 7));
      bus.lu_wd    = $urandom;
      bus.issue_en = ($urandom_range(0, 99) < 30);
      bus.issue_wr = 5'($urandom_range(0, 7));
      bus.chk_r1   = 5'($urandom_range(0, 7));
      bus.chk_r2   = 5'($urandom_range(0, 7));
      #1;
      checks++; if (bus.lu_ready !== m_ready()) begin failures++; $display("FAIL rnd_lu_ready n=%0d got=%0b exp=%0b", n, bus.lu_ready, m_ready()); end
      checks++; if (bus.chk_busy !== m_chk(bus.chk_r1, bus.chk_r2)) begin failures++; $display("FAIL rnd_chk_busy n=%0d got=%0b exp=%0b", n, bus.chk_busy, m_chk(bus.chk_r1, bus.chk_r2)); end
      step();
      checks++; if (bus.regWrite !== m_regw) begin failures++; $display("FAIL rnd_regWrite n=%0d got=%0b exp=%0b", n, bus.regWrite, m_regw); end
      checks++; if (bus.writeR !== m_wr || bus.writeD !== m_wd) begin failures++; $display("FAIL rnd_write n=%0d got=r%0d/%h exp=r%0d/%h", n, bus.writeR, bus.writeD, m_wr, m_wd); end
      checks++; if (int'(bus.fifo_count) != mq.size()) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, bus.fifo_count, mq.size()); end
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    bus.chk_r1 = '0;
    bus.chk_r2 = '0;
    test_reset();
    test_pipe_write();
    test_issue_complete();
    test_priority_backpressure();
    test_mid_reset();
    test_same_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
